rr_select_arbiter: RTL and testbench
====================================

Name: rr_select_arbiter

Overview:
- Four-requester round-robin arbiter directly upstream of the 2-to-4 decoder.
- Produces a registered 2-bit grant index plus a valid flag. The decoder turns the index into a one-hot grant; grant_valid gates that one-hot grant downstream.
- A grant is held while the winner keeps requesting, up to a bounded number of cycles. Fairness is guaranteed by a rotating priority pointer.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request lines; req[i] high = requester i wants the shared resource
- grant_idx  output  2  index of the granted requester; feeds the decoder select input
- grant_valid  output  1  high when grant_idx is a live grant
- hold_cnt  output  8  cycles the current grant has been held, starting at 0; for debug and visibility

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - grant_idx=2'b00, grant_valid=0, hold_cnt=0.
  - Priority pointer ptr=0; state=IDLE.
  - Takes effect immediately, even mid-grant. First arbitration after release uses ptr=0.
- Pick function, combinational: scan req starting at ptr upward modulo 4 (ptr, ptr+1, ptr+2, ptr+3); the first asserted bit wins.
- State IDLE:
  - If req==0: stay; grant_valid=0 and grant_idx keeps its last value.
  - Else on the next edge: state=GRANT, grant_valid=1, grant_idx=winner, hold_cnt=0, ptr=winner+1 (2-bit wrap, 3->0).
  - Latency: request visible at edge N gives the grant registered at edge N+1.
- State GRANT, evaluated each edge. Release condition = req[grant_idx]==0 OR hold_cnt==MAX_HOLD-1.
  - No release: hold; hold_cnt increments, and grant_idx/ptr are unchanged.
  - Release with some req bit set: re-arbitrate from ptr with the pick function, with no idle cycle in between.
    - A timed-out requester still asserting is eligible but has the lowest priority, because ptr already points past it.
    - Set grant_idx=winner, hold_cnt=0, ptr=winner+1, and stay in GRANT.
    - If the timed-out requester is the only one requesting, it is re-granted immediately and hold_cnt restarts at 0.
  - Release with req==0: state=IDLE, grant_valid=0, hold_cnt=0.
- Maximum grant duration is exactly MAX_HOLD cycles. With MAX_HOLD=1, the grant rotates every cycle among active requesters.
- hold_cnt never exceeds MAX_HOLD-1, so no overflow is possible.
- req changes take effect only at clock edges. Requests from non-granted requesters never preempt a grant.
- All outputs are registered; there are no combinational paths from req to the outputs.

Decomposition:
- Shared package rr_arb_pkg holds:
  - NUM_REQ=4 and IDX_W=2
  - the state enum {IDLE, GRANT}
  - HOLD_W=8
- One natural combinational sub-module: rr_priority_pick.
  - Inputs: req[3:0] and ptr[1:0].
  - Outputs: any (1 bit) and win_idx (2 bits).
  - The top instantiates it once and reuses it for both the IDLE and GRANT paths.

Test Plan:
- Reset, idle: hold rst_n=0, then release with req=0 for 5 cycles -> grant_valid=0, grant_idx=0, hold_cnt=0 throughout.
- Single requester, hold then drop, MAX_HOLD=8: req=4'b0100 from cycle 1, dropped at cycle 4 ->
  - grant_valid=1 and grant_idx=2 from edge 2, with hold_cnt 0,1,2 on successive cycles;
  - grant_valid=0 one edge after the drop is sampled.
- Timeout and rotation, MAX_HOLD=8: req=4'b0101 held steady ->
  - grant_idx=0 for 8 cycles, then 2 for 8 cycles, then 0 again;
  - grant_valid never deasserts and no idle cycle appears.
- Fair rotation, MAX_HOLD=1: req=4'b1111 -> grant_idx sequence 0,1,2,3,0,1 on consecutive cycles.
- Lone timeout re-grant, MAX_HOLD=4: req=4'b1000 held ->
  - grant_idx=3 continuously;
  - hold_cnt runs 0,1,2,3,0,1,... and grant_valid stays 1.
- Reset mid-grant: during a grant of requester 1, assert rst_n low asynchronously between edges ->
  - outputs go to 0 immediately, before the next edge;
  - after release with req=4'b0011, the first grant is index 0 because ptr was reset.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared widths and state type for the round-robin select arbiter
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Priority pointer always lands one past the winner, wrapping within IDX_W bits.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] winner);
    return winner + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotating-priority first-set scan over the request vector
module rr_priority_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   win_idx
);

  // Walk offsets from farthest to nearest so the nearest asserted bit to ptr wins last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    any     = |req;
    win_idx = ptr;
    cand    = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// rtl/rr_select_arbiter.sv - four-way round-robin arbiter with bounded grant hold
module rr_select_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic [HOLD_W-1:0]  hold_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_d;
  logic [HOLD_W-1:0] cnt_d;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              release_grant;

  // One scanner serves both the idle arbitration and the re-arbitration on release.
  rr_priority_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  assign release_grant = !req[grant_idx] || (hold_cnt == HOLD_LAST);
  assign grant_valid   = (state_q == GRANT);

  // Next-state logic: hold while the owner keeps asking, otherwise pick again from ptr.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = grant_idx;
    cnt_d   = hold_cnt;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          cnt_d   = '0;
          ptr_d   = next_ptr(pick_idx);
        end
      end
      GRANT: begin
        if (!release_grant) begin
          cnt_d = hold_cnt + HOLD_W'(1);
        end else if (pick_any) begin
          idx_d = pick_idx;
          cnt_d = '0;
          ptr_d = next_ptr(pick_idx);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, pointer and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_idx <= '0;
      hold_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_idx <= idx_d;
      hold_cnt  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb/tb_rr_select_arbiter.sv - randomized and directed checks of rr_select_arbiter against a reference model
module tb_rr_select_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] gi   [3];
  logic       gv   [3];
  logic [7:0] hc   [3];

  int max_h [3];
  int m_valid [3];
  int m_idx   [3];
  int m_cnt   [3];
  int m_ptr   [3];

  int n_pass;
  int n_total;

  initial begin
    max_h[0] = 8;
    max_h[1] = 1;
    max_h[2] = 4;
  end

  rr_select_arbiter #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant_idx(gi[0]), .grant_valid(gv[0]), .hold_cnt(hc[0])
  );
  rr_select_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant_idx(gi[1]), .grant_valid(gv[1]), .hold_cnt(hc[1])
  );
  rr_select_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant_idx(gi[2]), .grant_valid(gv[2]), .hold_cnt(hc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic int first_from(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // Reference model: owner keeps the resource until it stops asking or uses up its
  // MAX_HOLD cycles; then the first requester at or after the pointer takes over.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      int w;
      if (!rst_n) begin
        m_valid[i] <= 0; m_idx[i] <= 0; m_cnt[i] <= 0; m_ptr[i] <= 0;
      end else begin
        w = first_from(m_ptr[i], req);
        if (m_valid[i] != 0 && req[m_idx[i]] && m_cnt[i] < max_h[i] - 1) begin
          m_cnt[i] <= m_cnt[i] + 1;
        end else if (w >= 0) begin
          m_valid[i] <= 1; m_idx[i] <= w; m_cnt[i] <= 0; m_ptr[i] <= (w + 1) % 4;
        end else begin
          m_valid[i] <= 0; m_cnt[i] <= 0;
        end
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_valid[%0d]", i), int'(gv[i]), m_valid[i]);
      chk($sformatf("model_idx[%0d]", i),   int'(gi[i]), m_idx[i]);
      chk($sformatf("model_cnt[%0d]", i),   int'(hc[i]), m_cnt[i]);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_valid", int'(gv[0]), 0);
      chk("idle_idx",   int'(gi[0]), 0);
      chk("idle_cnt",   int'(hc[0]), 0);
    end

    // Single requester holds then drops.
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("single_valid", int'(gv[0]), 1);
      chk("single_idx",   int'(gi[0]), 2);
      chk("single_cnt",   int'(hc[0]), k);
    end
    req = 4'b0000;
    @(negedge clk);
    chk("single_drop_valid", int'(gv[0]), 0);

    // Timeout rotation between 0 and 2 with MAX_HOLD=8.
    do_reset();
    req = 4'b0101;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk("rot_valid", int'(gv[0]), 1);
      chk("rot_idx",   int'(gi[0]), (k < 8) ? 0 : ((k < 16) ? 2 : 0));
    end

    // Fair rotation with MAX_HOLD=1.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("fair_idx", int'(gi[1]), k % 4);
    end

    // Lone requester re-granted after timeout with MAX_HOLD=4.
    do_reset();
    req = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("lone_idx",   int'(gi[2]), 3);
      chk("lone_cnt",   int'(hc[2]), k % 4);
      chk("lone_valid", int'(gv[2]), 1);
    end

    // Asynchronous reset in the middle of a grant to requester 1.
    do_reset();
    req = 4'b0010;
    repeat (3) @(negedge clk);
    chk("pre_rst_idx", int'(gi[0]), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", int'(gv[0]), 0);
    chk("async_idx",   int'(gi[0]), 0);
    chk("async_cnt",   int'(hc[0]), 0);
    @(negedge clk);
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idx",   int'(gi[0]), 0);
    chk("post_rst_valid", int'(gv[0]), 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
      if ($urandom_range(149) == 0) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
